// File: rtl/bsg_demux_one_hot_pkg.sv
// rtl/bsg_demux_one_hot_pkg.sv - shared state encoding and select legality helper
package bsg_demux_one_hot_pkg;

    localparam int sel_max_width_lp = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } bsg_demux_buf_state_e;

    // Callers zero-extend their select to sel_max_width_lp bits.
    function automatic logic is_one_hot(input logic [sel_max_width_lp-1:0] sel);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < sel_max_width_lp; i++) begin
            cnt = cnt + 7'(sel[i]);
        end
        return cnt == 7'd1;
    endfunction

endpackage

// File: rtl/bsg_demux_one_hot_buf2.sv
// rtl/bsg_demux_one_hot_buf2.sv - two-entry data+select buffer with EMPTY/ONE/TWO FSM
module bsg_demux_one_hot_buf2
    import bsg_demux_one_hot_pkg::*;
#(
    parameter int width_p = 41,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic [els_p-1:0]   sel_i,
    input  logic               deq_i,
    output logic               ready_o,
    output logic               head_v_o,
    output logic [width_p-1:0] head_data_o,
    output logic [els_p-1:0]   head_sel_o
);

    bsg_demux_buf_state_e state_r, state_n;
    logic [width_p-1:0]   data_r [2];
    logic [els_p-1:0]     sel_r  [2];
    logic                 wptr_r, rptr_r;
    logic                 enq_ok, deq_ok;

    assign enq_ok = enq_i & ready_o;
    assign deq_ok = deq_i & head_v_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= EMPTY;
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_r[i] <= '0;
                sel_r[i]  <= '0;
            end
        end else begin
            state_r <= state_n;
            if (enq_ok) begin
                data_r[wptr_r] <= data_i;
                sel_r[wptr_r]  <= sel_i;
                wptr_r         <= ~wptr_r;
            end
            if (deq_ok) begin
                rptr_r <= ~rptr_r;
            end
        end
    end

    // ready_o and head_v_o decode only the state register, never ready_i.
    always_comb begin
        state_n     = state_r;
        ready_o     = (state_r != TWO);
        head_v_o    = (state_r == ONE) || (state_r == TWO);
        head_data_o = data_r[rptr_r];
        head_sel_o  = sel_r[rptr_r];
        case (state_r)
            EMPTY: if (enq_ok) state_n = ONE;
            ONE: begin
                if (enq_ok && !deq_ok)      state_n = TWO;
                else if (!enq_ok && deq_ok) state_n = EMPTY;
            end
            TWO:     if (deq_ok) state_n = ONE;
            default: state_n = EMPTY;
        endcase
    end

endmodule

// File: rtl/bsg_demux_one_hot_buffered.sv
// rtl/bsg_demux_one_hot_buffered.sv - buffered one-hot demux; BSG_DEMUX_ONE_HOT_DROP_CNT_EN adds drop_count_o
module bsg_demux_one_hot_buffered
    import bsg_demux_one_hot_pkg::*;
#(
    parameter int width_p          = 41,
    parameter int els_p            = 4,
    parameter int drop_cnt_width_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [els_p-1:0]         sel_one_hot_i,
    output logic                     ready_o,
    output logic [els_p-1:0]         v_o,
    output logic [els_p*width_p-1:0] data_o,
    input  logic [els_p-1:0]         ready_i,
    output logic                     err_o
`ifdef BSG_DEMUX_ONE_HOT_DROP_CNT_EN
    ,
    output logic [drop_cnt_width_p-1:0] drop_count_o
`endif
);

    if (els_p < 1 || els_p > sel_max_width_lp || drop_cnt_width_p < 1) begin : g_bad_param
        $error("bsg_demux_one_hot_buffered: illegal parameterisation");
    end

    logic               sel_legal, accept, deq;
    logic               head_v;
    logic [width_p-1:0] head_data;
    logic [els_p-1:0]   head_sel;
    logic               err_r;

    assign sel_legal = is_one_hot(sel_max_width_lp'(sel_one_hot_i));
    assign accept    = v_i & ready_o;

    bsg_demux_one_hot_buf2 #(
        .width_p (width_p),
        .els_p   (els_p)
    ) buf2 (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .enq_i       (accept & sel_legal),
        .data_i      (data_i),
        .sel_i       (sel_one_hot_i),
        .deq_i       (deq),
        .ready_o     (ready_o),
        .head_v_o    (head_v),
        .head_data_o (head_data),
        .head_sel_o  (head_sel)
    );

    // Unselected lanes are forced to zero so stale buffer contents never leak out.
    always_comb begin
        v_o    = '0;
        data_o = '0;
        for (int k = 0; k < els_p; k++) begin
            v_o[k] = head_v & head_sel[k];
            if (head_v && head_sel[k]) begin
                data_o[k*width_p +: width_p] = head_data;
            end
        end
    end

    assign deq = |(v_o & ready_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) err_r <= 1'b0;
        else            err_r <= accept & ~sel_legal;
    end

    assign err_o = err_r;

`ifdef BSG_DEMUX_ONE_HOT_DROP_CNT_EN
    logic [drop_cnt_width_p-1:0] drop_cnt_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_cnt_r <= '0;
        end else if (accept && !sel_legal && drop_cnt_r != '1) begin
            drop_cnt_r <= drop_cnt_r + 1'b1;
        end
    end

    assign drop_count_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_bsg_demux_one_hot_buffered.sv
// tb/tb_bsg_demux_one_hot_buffered.sv - self-checking bench for bsg_demux_one_hot_buffered
module tb_bsg_demux_one_hot_buffered;

    localparam int W = 41;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           v_i;
    logic [W-1:0]   data_i;
    logic [N-1:0]   sel;
    logic           ready_o;
    logic [N-1:0]   v_o;
    logic [N*W-1:0] data_o;
    logic [N-1:0]   ready_i;
    logic           err_o;
`ifdef BSG_DEMUX_ONE_HOT_DROP_CNT_EN
    logic [7:0]     drop_count;
`endif

    bsg_demux_one_hot_buffered #(
        .width_p          (W),
        .els_p            (N),
        .drop_cnt_width_p (8)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .v_i           (v_i),
        .data_i        (data_i),
        .sel_one_hot_i (sel),
        .ready_o       (ready_o),
        .v_o           (v_o),
        .data_o        (data_o),
        .ready_i       (ready_i),
        .err_o         (err_o)
`ifdef BSG_DEMUX_ONE_HOT_DROP_CNT_EN
        ,
        .drop_count_o  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: a FIFO of at most two legal words, plus pending error flag.
    typedef struct {
        logic [W-1:0] d;
        logic [N-1:0] s;
    } word_t;

    word_t          q[$];
    logic           err_exp = 1'b0;
    int             drop_exp = 0;
    int             deliveries = 0;
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    logic           m_acc, m_deq;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            err_exp  = 1'b0;
            drop_exp = 0;
        end
        ev = (q.size() > 0) ? q[0].s : '0;
        ed = '0;
        for (int k = 0; k < N; k++) begin
            if (ev[k]) ed[k*W +: W] = q[0].d;
        end
        check("m_ready_o", 256'(ready_o), 256'(q.size() < 2));
        check("m_v_o", 256'(v_o), 256'(ev));
        check("m_data_o", 256'(data_o), 256'(ed));
        check("m_err_o", 256'(err_o), 256'(err_exp));
`ifdef BSG_DEMUX_ONE_HOT_DROP_CNT_EN
        check("m_drop_count", 256'(drop_count), 256'(drop_exp));
`endif
        if (rst_n) begin
            m_deq = (q.size() > 0) && ((q[0].s & ready_i) != '0);
            m_acc = v_i && (q.size() < 2);
            if (m_deq) begin
                void'(q.pop_front());
                deliveries++;
            end
            err_exp = m_acc && ($countones(sel) != 1);
            if (m_acc && $countones(sel) == 1) q.push_back('{data_i, sel});
            if (err_exp && drop_exp < 255) drop_exp++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] lane(input int k, input logic [W-1:0] d);
        logic [N*W-1:0] r;
        r = '0;
        r[k*W +: W] = d;
        return r;
    endfunction

    localparam logic [W-1:0] WA = 41'h0AA_5555_1234;
    localparam logic [W-1:0] WB = 41'h1BB_0F0F_9876;
    localparam logic [W-1:0] WE = 41'h0EE_1357_2468;

    int base;

    initial begin
        rst_n = 1'b0; v_i = 1'b0; data_i = '0; sel = '0; ready_i = '0;
        step(); step();
        check("rst_ready_o", 256'(ready_o), 256'(1'b1));
        check("rst_v_o", 256'(v_o), 256'(0));
        check("rst_data_o", 256'(data_o), 256'(0));
        check("rst_err_o", 256'(err_o), 256'(0));
        rst_n = 1'b1;
        step();

        // Basic routing and one-cycle latency
        ready_i = 4'hF; v_i = 1'b1; data_i = 41'h1_2345_6789; sel = 4'b0100;
        step();
        v_i = 1'b0;
        check("basic_v_o", 256'(v_o), 256'(4'b0100));
        check("basic_data_o", 256'(data_o), 256'(lane(2, 41'h1_2345_6789)));
        step();
        check("basic_v_o_after", 256'(v_o), 256'(0));

        // Backpressure fill and head-of-line blocking
        ready_i = 4'h0; v_i = 1'b1; data_i = WA; sel = 4'b0001;
        step();
        data_i = WB; sel = 4'b1000;
        step();
        v_i = 1'b0;
        check("bp_ready_o_full", 256'(ready_o), 256'(0));
        check("bp_v_o_a", 256'(v_o), 256'(4'b0001));
        check("bp_data_a", 256'(data_o), 256'(lane(0, WA)));
        ready_i = 4'b1000;
        step();
        check("bp_hol_v_o", 256'(v_o), 256'(4'b0001));
        check("bp_hol_ready_o", 256'(ready_o), 256'(0));
        ready_i = 4'b0001;
        step();
        check("bp_v_o_b", 256'(v_o), 256'(4'b1000));
        check("bp_data_b", 256'(data_o), 256'(lane(3, WB)));
        check("bp_ready_o_one", 256'(ready_o), 256'(1));
        ready_i = 4'hF;
        step();

        // Streaming at one word per cycle
        base = deliveries;
        for (int i = 0; i < 10; i++) begin
            v_i = 1'b1; data_i = W'(100 + i); sel = 4'(1 << (i % 4));
            step();
            check("stream_ready_o", 256'(ready_o), 256'(1));
        end
        v_i = 1'b0;
        step(); step();
        check("stream_delivered", 256'(deliveries - base), 256'(10));

        // Illegal selects
        v_i = 1'b1; data_i = 41'h3; sel = 4'b0000;
        step();
        check("ill_err_zero", 256'(err_o), 256'(1));
        sel = 4'b0110;
        step();
        v_i = 1'b0;
        check("ill_err_multi", 256'(err_o), 256'(1));
        check("ill_v_o", 256'(v_o), 256'(0));
        step();
        check("ill_err_clear", 256'(err_o), 256'(0));
`ifdef BSG_DEMUX_ONE_HOT_DROP_CNT_EN
        check("drop_cnt_two", 256'(drop_count), 256'(2));
        v_i = 1'b1; sel = 4'b0000;
        for (int i = 0; i < 300; i++) step();
        v_i = 1'b0;
        step();
        check("drop_cnt_sat", 256'(drop_count), 256'(255));
`endif

        // Asynchronous reset while full
        ready_i = 4'h0; v_i = 1'b1; data_i = 41'hC; sel = 4'b0010;
        step();
        data_i = 41'hD; sel = 4'b0100;
        step();
        v_i = 1'b0;
        check("mid_full", 256'(ready_o), 256'(0));
        #2 rst_n = 1'b0;
        #1;
        check("mid_v_o", 256'(v_o), 256'(0));
        check("mid_data_o", 256'(data_o), 256'(0));
        check("mid_ready_o", 256'(ready_o), 256'(1));
        step();
        rst_n = 1'b1;
        ready_i = 4'hF;
        step();
        check("post_ready_o", 256'(ready_o), 256'(1));
        check("post_v_o", 256'(v_o), 256'(0));
        v_i = 1'b1; data_i = WE; sel = 4'b0001;
        step();
        v_i = 1'b0;
        check("post_data_e", 256'(data_o), 256'(lane(0, WE)));
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
